// File: rtl/water_reminder_scheduler_pkg.sv
// Shared types and default timing constants for the water-reminder datapath.
// The tick defaults are also consumed by the display logic.
package water_reminder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ALERT  = 2'd2,
    ST_SNOOZE = 2'd3
  } sched_state_t;

  localparam int unsigned MISSED_W             = 4;
  localparam int unsigned DEFAULT_TICK_DIV     = 50_000_000;
  localparam int unsigned DEFAULT_INTERVAL_W   = 12;
  localparam int unsigned DEFAULT_SNOOZE_TICKS = 300;
  localparam int unsigned DEFAULT_REPEAT_TICKS = 60;
  localparam int unsigned DEFAULT_MAX_REPEATS  = 3;

  function automatic logic [MISSED_W-1:0] sat_inc_missed(input logic [MISSED_W-1:0] v);
    return (v == '1) ? v : v + MISSED_W'(1);
  endfunction

endpackage

// File: rtl/water_reminder_scheduler_if.sv
// Scheduler-facing bundle: user/extender inputs and registered status outputs.
interface water_reminder_scheduler_if #(
  parameter int unsigned INTERVAL_W = 12
);
  import water_reminder_pkg::*;

  logic                  enable;
  logic [INTERVAL_W-1:0] interval;
  logic                  ack;
  logic                  snooze;
  logic                  ext_active;
  logic                  reminder;
  logic [1:0]            state;
  logic [MISSED_W-1:0]   missed_count;
  logic [INTERVAL_W-1:0] remaining;

  modport master (
    output enable, interval, ack, snooze, ext_active,
    input  reminder, state, missed_count, remaining
  );

  modport slave (
    input  enable, interval, ack, snooze, ext_active,
    output reminder, state, missed_count, remaining
  );

endinterface

// File: rtl/water_reminder_scheduler_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles while running.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick = run && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = tick ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/water_reminder_scheduler.sv
// Reminder scheduler: interval countdown, alert/snooze handling, repeat and
// missed-reminder accounting, and the one-cycle reminder pulse to the extender.
module water_reminder_scheduler
  import water_reminder_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int unsigned INTERVAL_W   = DEFAULT_INTERVAL_W,
  parameter int unsigned SNOOZE_TICKS = DEFAULT_SNOOZE_TICKS,
  parameter int unsigned REPEAT_TICKS = DEFAULT_REPEAT_TICKS,
  parameter int unsigned MAX_REPEATS  = DEFAULT_MAX_REPEATS
) (
  input logic                       clk,
  input logic                       reset,
  water_reminder_scheduler_if.slave bus
);

  localparam int unsigned REP_W = 4;
  localparam logic [INTERVAL_W-1:0] SNOOZE_RELOAD = INTERVAL_W'(SNOOZE_TICKS);
  localparam logic [INTERVAL_W-1:0] REPEAT_RELOAD = INTERVAL_W'(REPEAT_TICKS);
  localparam logic [REP_W-1:0]      REP_LAST      = REP_W'(MAX_REPEATS - 1);

  sched_state_t          state_q, state_d;
  logic [INTERVAL_W-1:0] remaining_q, remaining_d;
  logic [REP_W-1:0]      rep_q, rep_d;
  logic [MISSED_W-1:0]   missed_q, missed_d;
  logic                  pend_q, pend_d;
  logic                  reminder_q, reminder_d;

  logic                  tick;
  logic                  reload;
  logic                  expire;
  logic [INTERVAL_W-1:0] interval_target;

  assign interval_target = (bus.interval == '0) ? INTERVAL_W'(1) : bus.interval;
  assign expire          = tick && (remaining_q == INTERVAL_W'(1));

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (state_q != ST_IDLE),
    .clear ((state_q == ST_IDLE) || !bus.enable || reload),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    rep_d       = rep_q;
    missed_d    = missed_q;
    pend_d      = pend_q;
    reminder_d  = 1'b0;
    reload      = 1'b0;

    if (!bus.enable) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      rep_d       = '0;
      pend_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d     = ST_COUNT;
          remaining_d = interval_target;
          reload      = 1'b1;
        end

        ST_COUNT: begin
          if (expire) begin
            state_d     = ST_ALERT;
            remaining_d = REPEAT_RELOAD;
            pend_d      = 1'b1;
            reload      = 1'b1;
          end else if (tick) begin
            remaining_d = remaining_q - INTERVAL_W'(1);
          end
        end

        ST_ALERT: begin
          // Issue first so a response in the same cycle cannot swallow a pulse
          // that was already cleared to go; a repeat below may re-arm pend.
          if (pend_q && !bus.ext_active) begin
            reminder_d = 1'b1;
            pend_d     = 1'b0;
          end
          if (bus.ack) begin
            state_d     = ST_COUNT;
            remaining_d = interval_target;
            rep_d       = '0;
            pend_d      = 1'b0;
            reload      = 1'b1;
          end else if (bus.snooze) begin
            state_d     = ST_SNOOZE;
            remaining_d = SNOOZE_RELOAD;
            rep_d       = '0;
            pend_d      = 1'b0;
            reload      = 1'b1;
          end else if (expire) begin
            reload = 1'b1;
            if (rep_q < REP_LAST) begin
              rep_d       = rep_q + REP_W'(1);
              pend_d      = 1'b1;
              remaining_d = REPEAT_RELOAD;
            end else begin
              state_d     = ST_COUNT;
              missed_d    = sat_inc_missed(missed_q);
              rep_d       = '0;
              remaining_d = interval_target;
            end
          end else if (tick) begin
            remaining_d = remaining_q - INTERVAL_W'(1);
          end
        end

        ST_SNOOZE: begin
          if (bus.ack) begin
            state_d     = ST_COUNT;
            remaining_d = interval_target;
            reload      = 1'b1;
          end else if (expire) begin
            state_d     = ST_ALERT;
            remaining_d = REPEAT_RELOAD;
            pend_d      = 1'b1;
            reload      = 1'b1;
          end else if (tick) begin
            remaining_d = remaining_q - INTERVAL_W'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      rep_q       <= '0;
      missed_q    <= '0;
      pend_q      <= 1'b0;
      reminder_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rep_q       <= rep_d;
      missed_q    <= missed_d;
      pend_q      <= pend_d;
      reminder_q  <= reminder_d;
    end
  end

  assign bus.reminder     = reminder_q;
  assign bus.state        = state_q;
  assign bus.missed_count = missed_q;
  assign bus.remaining    = remaining_q;

endmodule

// File: tb/tb_water_reminder_scheduler.sv
// Directed bench for water_reminder_scheduler with TICK_DIV=4, interval=3,
// SNOOZE=2, REPEAT=2, MAX_REPEATS=2; expected values are hand-derived cycle counts.
module tb_water_reminder_scheduler;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pulses;
  int   waited;

  water_reminder_scheduler_if #(.INTERVAL_W(12)) bus ();

  water_reminder_scheduler #(
    .TICK_DIV     (4),
    .INTERVAL_W   (12),
    .SNOOZE_TICKS (2),
    .REPEAT_TICKS (2),
    .MAX_REPEATS  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.reminder) pulses++;
    end
  endtask

  task automatic wait_reminder(input int budget, output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (!bus.reminder && cycles < budget);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    reset = 1'b0;
    bus.enable     = 1'b0;
    bus.interval   = 12'd3;
    bus.ack        = 1'b0;
    bus.snooze     = 1'b0;
    bus.ext_active = 1'b0;

    step(3);
    check_eq("rst_state",    32'(bus.state),        32'd0);
    check_eq("rst_remain",   32'(bus.remaining),    32'd0);
    check_eq("rst_missed",   32'(bus.missed_count), 32'd0);
    check_eq("rst_reminder", 32'(bus.reminder),     32'd0);
    reset = 1'b1;
    step(1);
    check_eq("idle_hold", 32'(bus.state), 32'd0);

    // Basic cycle
    pulses = 0;
    bus.enable = 1'b1;
    step(1);
    check_eq("basic_count", 32'(bus.state),     32'd1);
    check_eq("basic_rem3",  32'(bus.remaining), 32'd3);
    step(4);
    check_eq("basic_rem2",  32'(bus.remaining), 32'd2);
    step(4);
    check_eq("basic_rem1",  32'(bus.remaining), 32'd1);
    step(4);
    check_eq("basic_alert", 32'(bus.state),     32'd2);
    check_eq("basic_nopulse_yet", 32'(bus.reminder), 32'd0);
    step(1);
    check_eq("basic_pulse", 32'(bus.reminder),  32'd1);
    step(1);
    check_eq("basic_pulse_end", 32'(bus.reminder), 32'd0);
    check_eq("basic_pulse_cnt", 32'(pulses),       32'd1);

    // Acknowledge 5 cycles after the pulse
    step(4);
    bus.ack = 1'b1;
    step(1);
    bus.ack = 1'b0;
    check_eq("ack_state",  32'(bus.state),        32'd1);
    check_eq("ack_rem",    32'(bus.remaining),    32'd3);
    check_eq("ack_missed", 32'(bus.missed_count), 32'd0);
    wait_reminder(40, waited);
    check_eq("ack_next_latency", 32'(waited), 32'd13);

    // Unanswered: repeat after 2 ticks, miss after 2 more
    wait_reminder(40, waited);
    check_eq("repeat_latency", 32'(waited), 32'd8);
    step(7);
    check_eq("miss1_count",  32'(bus.missed_count), 32'd1);
    check_eq("miss1_state",  32'(bus.state),        32'd1);
    check_eq("miss1_rem",    32'(bus.remaining),    32'd3);

    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      step(28);
      check_eq($sformatf("miss_sat_%0d", k), 32'(bus.missed_count),
               (k + 2 > 15) ? 32'd15 : 32'(k + 2));
    end
    check_eq("miss_loop_pulses", 32'(pulses),    32'd32);
    check_eq("miss_loop_state",  32'(bus.state), 32'd1);

    // Busy extender across ALERT entry
    pulses = 0;
    bus.ext_active = 1'b1;
    step(20);
    check_eq("busy_no_pulse", 32'(pulses), 32'd0);
    check_eq("busy_alert",    32'(bus.state), 32'd2);
    bus.ext_active = 1'b0;
    step(1);
    check_eq("busy_pulse_after_fall", 32'(bus.reminder), 32'd1);
    step(6);
    check_eq("busy_single_pulse", 32'(pulses), 32'd1);
    step(1);
    check_eq("busy_miss_state", 32'(bus.state),        32'd1);
    check_eq("busy_miss_sat",   32'(bus.missed_count), 32'd15);

    // Snooze, with a second snooze ignored while snoozing
    wait_reminder(40, waited);
    check_eq("snz_pre_latency", 32'(waited), 32'd13);
    bus.snooze = 1'b1;
    step(1);
    bus.snooze = 1'b0;
    check_eq("snz_state", 32'(bus.state),     32'd3);
    check_eq("snz_rem",   32'(bus.remaining), 32'd2);
    step(1);
    bus.snooze = 1'b1;
    step(1);
    bus.snooze = 1'b0;
    step(5);
    check_eq("snz_still",   32'(bus.state),     32'd3);
    check_eq("snz_rem1",    32'(bus.remaining), 32'd1);
    step(1);
    check_eq("snz_realert", 32'(bus.state),     32'd2);
    step(1);
    check_eq("snz_pulse",   32'(bus.reminder),  32'd1);

    // ack + snooze together, then enable=0 + ack together
    bus.ack = 1'b1;
    bus.snooze = 1'b1;
    step(1);
    bus.snooze = 1'b0;
    check_eq("acksnz_state", 32'(bus.state),     32'd1);
    check_eq("acksnz_rem",   32'(bus.remaining), 32'd3);
    bus.enable = 1'b0;
    step(1);
    bus.ack = 1'b0;
    check_eq("dis_state",  32'(bus.state),        32'd0);
    check_eq("dis_rem",    32'(bus.remaining),    32'd0);
    check_eq("dis_missed", 32'(bus.missed_count), 32'd15);

    // Reset in ALERT with pend held by a busy extender
    bus.enable = 1'b1;
    bus.ext_active = 1'b1;
    step(13);
    check_eq("rstmid_alert", 32'(bus.state), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rstmid_state",    32'(bus.state),        32'd0);
    check_eq("rstmid_rem",      32'(bus.remaining),    32'd0);
    check_eq("rstmid_missed",   32'(bus.missed_count), 32'd0);
    check_eq("rstmid_reminder", 32'(bus.reminder),     32'd0);
    bus.ext_active = 1'b0;
    step(2);
    reset = 1'b1;
    pulses = 0;
    step(10);
    check_eq("rstmid_no_pulse", 32'(pulses),    32'd0);
    check_eq("rstmid_resume",   32'(bus.state), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/water_reminder_scheduler.md
# water_reminder_scheduler

Sequences reminder events for the water-reminder datapath. Counts a programmable interval in prescaled ticks, then fires a one-cycle `reminder` pulse into the reminder pulse extender. While the alert is outstanding, it handles user acknowledge and snooze, re-issues unanswered reminders, and counts missed reminders. It sits between the user-input debouncers and the extender/display path.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per tick (1 s at 50 MHz); ≥2.
- `INTERVAL_W`, 12: width of `interval` and of the internal countdown.
- `SNOOZE_TICKS`, 300: ticks spent in SNOOZE before re-alerting; ≥1, < 2^INTERVAL_W.
- `REPEAT_TICKS`, 60: ticks without response before an alert repeats; ≥1, < 2^INTERVAL_W.
- `MAX_REPEATS`, 3: unanswered reminder pulses that count as one miss; 1..15.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `enable`  in  1  level; 0 forces IDLE.
- `interval`  in  INTERVAL_W  ticks between reminders; sampled at each reload; 0 treated as 1.
- `ack`  in  1  one-cycle pulse (debounced): user drank.
- `snooze`  in  1  one-cycle pulse (debounced): postpone current alert.
- `ext_active`  in  1  extender currently stretching a reminder.
- `reminder`  out  1  one-cycle pulse to extender.
- `state`  out  2  current state encoding.
- `missed_count`  out  4  saturating count of missed reminders.
- `remaining`  out  INTERVAL_W  current countdown value, for display.

## Operation
- States: IDLE=0, COUNT=1, ALERT=2, SNOOZE=3.
- Reload means: `remaining` <= target, prescaler <= 0.
- IDLE: `remaining`=0, prescaler held at 0. When `enable`=1: reload `max(interval,1)` and go to COUNT.
- COUNT: on tick, decrement `remaining`. On a tick with `remaining`==1: go to ALERT, reload REPEAT_TICKS, set `pend`.
- ALERT, reminder issue: while `pend`=1 and `ext_active`=0, register `reminder`=1 and clear `pend`. While `ext_active`=1, `pend` holds. The pulse is never dropped and never duplicated.
- ALERT, responses:
  - `ack`: clear `pend` and the repeat counter, reload interval, go to COUNT.
  - `snooze`: clear `pend` and the repeat counter, reload SNOOZE_TICKS, go to SNOOZE.
  - Tick with `remaining`==1 and repeat counter < MAX_REPEATS-1: increment the repeat counter, set `pend`, reload REPEAT_TICKS.
  - Tick with `remaining`==1 and repeat counter == MAX_REPEATS-1: `missed_count`++ (saturates at 15), clear the repeat counter, reload interval, go to COUNT.
- SNOOZE:
  - Tick with `remaining`==1: go to ALERT, reload REPEAT_TICKS, set `pend`.
  - `ack`: reload interval, go to COUNT.
  - `snooze` is ignored; snooze does not stack.
- Priority in any state: `enable`=0 > `ack` > `snooze` > tick expiry.
- `enable`=0 in any state: next state IDLE; clears `pend`, the repeat counter and `remaining`. `missed_count` is held.
- `ack` in IDLE or COUNT: no effect.
- `interval` changes take effect only at the next reload.

## Timing
- All outputs are registered. Reset values: `reminder`=0, `state`=IDLE, `missed_count`=0, `remaining`=0. Internal `pend`, repeat counter and prescaler all reset to 0.
- Tick: the prescaler counts 0..TICK_DIV-1 when not in IDLE. Tick is asserted combinationally in the cycle the prescaler is at TICK_DIV-1, then the prescaler wraps to 0.
- Reminder latency: for tick-expiry cycle N, `state`=ALERT at N+1 and `reminder`=1 at N+2 if `ext_active`=0 at N+1. Otherwise `reminder`=1 on the cycle after `ext_active` is first sampled 0.
- Responses:
  - A response in cycle N is reflected in `state` at N+1.
  - A response coinciding with a tick uses the response path; no decrement and no repeat in that cycle.
  - `ack` in the same cycle as the `reminder` pulse is legal. That pulse still issues.
- Reset mid-operation: everything returns to reset values immediately, with no `reminder` glitch.

## Structure
- Shared package `water_reminder_pkg`:
  - `sched_state_t` enum (2-bit, the encodings above).
  - `MISSED_W`=4.
  - Default tick constants, shared with the display logic.
- One sub-module, `tick_prescaler`:
  - Parameters: `TICK_DIV`.
  - Ports: `clk`, `reset`, `run`, `clear`, `tick`.
  - Counts while `run`=1; `clear` has priority and zeroes the count.
- The scheduler FSM, countdown, repeat counter and `pend` flag live in the top module.

## Test plan
All scenarios use TICK_DIV=4, SNOOZE_TICKS=2, REPEAT_TICKS=2, MAX_REPEATS=2, `interval`=3, and `ext_active`=0 unless stated.
- Basic cycle: `enable`=1 after reset → `state`=COUNT, then exactly one `reminder` pulse 2 cycles after the 3rd tick; `remaining` reads 3,2,1 across ticks.
- Acknowledge: `ack` 5 cycles after `reminder` → COUNT with `remaining`=3; the next reminder arrives 12 cycles later (+2 latency); `missed_count`=0.
- Missed reminder: no response → reminder, repeat after 2 ticks, then after 2 more ticks `missed_count`=1 and `state`=COUNT. Run 16 further misses → `missed_count` stays at 15.
- Busy extender: hold `ext_active`=1 for 20 cycles across ALERT entry → `reminder` pulses exactly once, the cycle after `ext_active` falls.
- Snooze and simultaneous events:
  - `snooze` → SNOOZE, re-ALERT after 2 ticks.
  - `ack` and `snooze` in the same cycle → COUNT.
  - `enable`=0 and `ack` in the same cycle → IDLE with `remaining`=0.
- Reset: deassert `reset` (drive 0) mid-ALERT with `pend`=1 → all outputs at reset values; no `reminder` pulse after release.
